// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// This block shares the register file's single write port between two
// writeback sources:
//   - EX, which returns ALU and branch-link results.
//   - MEM, which returns load results.
//
// Each source owns a one-entry holding buffer. The arbiter grants the older
// buffered entry first, so writes to the same register commit in program
// order.
//
// Handshake (both sources): an entry transfers on a clock edge where
// src_valid && src_ready. src_ready is combinational from registered state
// and equals !buf_valid || buf_granted, so a buffer refills on the same edge
// it drains. An entry with rd == 0 completes the handshake but is dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid/ex_ready/ex_rd/ex_data      EX writeback request
//   mem_valid/mem_ready/mem_rd/mem_data  MEM writeback request
//   wb_we/wb_rd/wb_data           registered register-file write port
//   pending_mask                  bit r set while a write to xr is buffered
//                                 or in flight on the wb port
//   conflict_cnt                  saturating count of cycles in which both
//                                 buffers were valid
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN          = 32,
    parameter int TIE_MEM_FIRST = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [4:0]       ex_rd,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic TIE_BIT = (TIE_MEM_FIRST != 0);

    logic             ex_vld_q,  ex_vld_d;
    logic [4:0]       ex_rd_q,   ex_rd_d;
    logic [XLEN-1:0]  ex_data_q, ex_data_d;
    logic             mem_vld_q,  mem_vld_d;
    logic [4:0]       mem_rd_q,   mem_rd_d;
    logic [XLEN-1:0]  mem_data_q, mem_data_d;
    logic             mem_older_q, mem_older_d;
    logic             wb_we_q,   wb_we_d;
    logic [4:0]       wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic grant_ex, grant_mem;
    logic ex_load, mem_load;
    logic ex_stay, mem_stay;
    logic [31:0] pend;

    always_comb begin
        // With both buffers valid the age bit picks the older entry;
        // with only one valid the age bit is ignored.
        grant_ex  = ex_vld_q  && (!mem_vld_q || !mem_older_q);
        grant_mem = mem_vld_q && (!ex_vld_q  ||  mem_older_q);

        ex_ready  = !ex_vld_q  || grant_ex;
        mem_ready = !mem_vld_q || grant_mem;

        // Writes to x0 complete the handshake but never enter a buffer.
        ex_load  = ex_valid  && ex_ready  && (ex_rd  != 5'd0);
        mem_load = mem_valid && mem_ready && (mem_rd != 5'd0);

        // Entries that remain buffered across the edge (the arbitration loser).
        ex_stay  = ex_vld_q  && !grant_ex;
        mem_stay = mem_vld_q && !grant_mem;

        ex_vld_d   = ex_load ? 1'b1 : (grant_ex ? 1'b0 : ex_vld_q);
        ex_rd_d    = ex_load ? ex_rd   : ex_rd_q;
        ex_data_d  = ex_load ? ex_data : ex_data_q;
        mem_vld_d  = mem_load ? 1'b1 : (grant_mem ? 1'b0 : mem_vld_q);
        mem_rd_d   = mem_load ? mem_rd   : mem_rd_q;
        mem_data_d = mem_load ? mem_data : mem_data_q;

        // A newly loaded entry is always younger than one that stays behind.
        mem_older_d = mem_older_q;
        if (ex_load && mem_load) begin
            mem_older_d = TIE_BIT;
        end else if (mem_load && ex_stay) begin
            mem_older_d = 1'b0;
        end else if (ex_load && mem_stay) begin
            mem_older_d = 1'b1;
        end

        wb_we_d   = grant_ex || grant_mem;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (grant_ex) begin
            wb_rd_d   = ex_rd_q;
            wb_data_d = ex_data_q;
        end else if (grant_mem) begin
            wb_rd_d   = mem_rd_q;
            wb_data_d = mem_data_q;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (ex_vld_q && mem_vld_q && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_q       <= 1'b0;
            ex_rd_q        <= '0;
            ex_data_q      <= '0;
            mem_vld_q      <= 1'b0;
            mem_rd_q       <= '0;
            mem_data_q     <= '0;
            mem_older_q    <= TIE_BIT;
            wb_we_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            ex_vld_q       <= ex_vld_d;
            ex_rd_q        <= ex_rd_d;
            ex_data_q      <= ex_data_d;
            mem_vld_q      <= mem_vld_d;
            mem_rd_q       <= mem_rd_d;
            mem_data_q     <= mem_data_d;
            mem_older_q    <= mem_older_d;
            wb_we_q        <= wb_we_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Hazard mask: every destination that is buffered or on the write port.
    always_comb begin
        pend = '0;
        if (ex_vld_q)  pend[ex_rd_q]  = 1'b1;
        if (mem_vld_q) pend[mem_rd_q] = 1'b1;
        if (wb_we_q)   pend[wb_rd_q]  = 1'b1;
        pend[0] = 1'b0;
    end

    assign pending_mask = pend;
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
